// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer for the CPU fetch stage
//
// Holds the fetch address and picks the next one from: trap vector, stall
// (hold), taken conditional branch, J/JAL, JR, RET, ERET, sequential pc+4.
// Optional hardware return-address stack, enabled by defining PC_SEQ_RAS_EN.
//
// Ports:
//   clk       rising-edge clock
//   rest_n    asynchronous active-low reset
//   stall     1 = hold PC (trap still taken)
//   trap      exception request
//   zero      compare result: equal
//   great     compare result: greater
//   pc_op     next-PC operation (PC_OP_* encodings below)
//   im1       branch offset in words, signed
//   im2       jump index
//   j_reg     register jump target
//   addr      current fetch address
//   rt_addr   link address (registered pc+4)
//   epc       saved exception PC
//   redirect  previous update was non-sequential
//   ras_empty return stack holds no entries (constant 1 without PC_SEQ_RAS_EN)

`ifndef PC_OP_SEQ
`define PC_OP_SEQ   4'd0
`define PC_OP_BZ    4'd1
`define PC_OP_BNZ   4'd2
`define PC_OP_BG    4'd3
`define PC_OP_BNG   4'd4
`define PC_OP_BGZ   4'd5
`define PC_OP_BNGNZ 4'd6
`define PC_OP_J     4'd7
`define PC_OP_JAL   4'd8
`define PC_OP_JR    4'd9
`define PC_OP_RET   4'd10
`define PC_OP_ERET  4'd11
`endif

module pc_seq #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [31:0]       TRAP_ADDR  = 32'h0000_0080,
    parameter int                 RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rest_n,
    input  logic              stall,
    input  logic              trap,
    input  logic              zero,
    input  logic              great,
    input  logic [3:0]        pc_op,
    input  logic [15:0]       im1,
    input  logic [25:0]       im2,
    input  logic [ADDR_W-1:0] j_reg,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] rt_addr,
    output logic [ADDR_W-1:0] epc,
    output logic              redirect,
    output logic              ras_empty
);

    if (ADDR_W < 32 || ADDR_W > 64 || RAS_DEPTH < 2 || RAS_DEPTH > 16 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
        $error("pc_seq: illegal ADDR_W or RAS_DEPTH");
    end

    localparam logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(TRAP_ADDR);

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_redirect;
    logic              take_br;
    logic              advance;

    assign seq_addr   = addr + ADDR_W'(4);
    // Branch offset is relative to the current PC, not pc+4.
    assign br_target  = addr + {{(ADDR_W-18){im1[15]}}, im1, 2'b00};
    assign jmp_target = {addr[ADDR_W-1:28], im2, 2'b00};
    assign advance    = !trap && !stall;

`ifdef PC_SEQ_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    // ras_ptr is the next slot to write; the top entry sits one below it.
    // When full, ras_ptr lands on the oldest entry, so a push overwrites it.
    logic [PTR_W-1:0]  ras_ptr;
    logic [CNT_W-1:0]  ras_cnt;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push;
    logic              ras_pop;

    assign ras_top   = ras_mem[ras_ptr - PTR_W'(1)];
    assign ras_empty = (ras_cnt == '0);
    assign ras_push  = advance && (pc_op == `PC_OP_JAL);
    assign ras_pop   = advance && (pc_op == `PC_OP_RET) && !ras_empty;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_cnt != RAS_FULL) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (ras_pop) begin
            ras_ptr <= ras_ptr - PTR_W'(1);
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

    // Storage is not reset; an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            ras_mem[ras_ptr] <= seq_addr;
        end
    end
`else
    assign ras_empty = 1'b1;
`endif

    always_comb begin
        take_br = 1'b0;
        case (pc_op)
            `PC_OP_BZ:    take_br = zero;
            `PC_OP_BNZ:   take_br = !zero;
            `PC_OP_BG:    take_br = great;
            `PC_OP_BNG:   take_br = !great;
            `PC_OP_BGZ:   take_br = zero | great;
            `PC_OP_BNGNZ: take_br = !zero & !great;
            default:      take_br = 1'b0;
        endcase
    end

    always_comb begin
        nxt_addr     = seq_addr;
        nxt_redirect = 1'b0;
        if (take_br) begin
            nxt_addr     = br_target;
            nxt_redirect = 1'b1;
        end else begin
            case (pc_op)
                `PC_OP_J, `PC_OP_JAL: begin
                    nxt_addr     = jmp_target;
                    nxt_redirect = 1'b1;
                end
                `PC_OP_JR: begin
                    nxt_addr     = j_reg;
                    nxt_redirect = 1'b1;
                end
                `PC_OP_RET: begin
`ifdef PC_SEQ_RAS_EN
                    // Empty stack falls back to the register target.
                    nxt_addr     = ras_empty ? j_reg : ras_top;
`else
                    nxt_addr     = j_reg;
`endif
                    nxt_redirect = 1'b1;
                end
                `PC_OP_ERET: begin
                    nxt_addr     = epc;
                    nxt_redirect = 1'b1;
                end
                default: begin
                    nxt_addr     = seq_addr;
                    nxt_redirect = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            addr     <= RESET_ADDR;
            rt_addr  <= '0;
            epc      <= '0;
            redirect <= 1'b0;
        end else if (trap) begin
            // Trap wins over stall and pc_op; rt_addr is left untouched.
            epc      <= addr;
            addr     <= TRAP_VEC;
            redirect <= 1'b1;
        end else if (stall) begin
            redirect <= 1'b0;
        end else begin
            addr     <= nxt_addr;
            rt_addr  <= seq_addr;
            redirect <= nxt_redirect;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq
module tb_pc_seq;

    localparam logic [3:0] OP_SEQ   = 4'd0;
    localparam logic [3:0] OP_BZ    = 4'd1;
    localparam logic [3:0] OP_BNZ   = 4'd2;
    localparam logic [3:0] OP_BG    = 4'd3;
    localparam logic [3:0] OP_BNG   = 4'd4;
    localparam logic [3:0] OP_BGZ   = 4'd5;
    localparam logic [3:0] OP_BNGNZ = 4'd6;
    localparam logic [3:0] OP_J     = 4'd7;
    localparam logic [3:0] OP_JAL   = 4'd8;
    localparam logic [3:0] OP_JR    = 4'd9;
    localparam logic [3:0] OP_RET   = 4'd10;
    localparam logic [3:0] OP_ERET  = 4'd11;

    localparam logic [31:0] RST_A  = 32'h100;
    localparam logic [31:0] TRAP_A = 32'h80;
    localparam int          RAS_D  = 2;

    logic        clk = 1'b0;
    logic        rest_n;
    logic        stall, trap, zero, great;
    logic [3:0]  pc_op;
    logic [15:0] im1;
    logic [25:0] im2;
    logic [31:0] j_reg;
    logic [31:0] addr, rt_addr, epc;
    logic        redirect, ras_empty;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_addr, m_rt, m_epc;
    logic        m_redir;
`ifdef PC_SEQ_RAS_EN
    logic [31:0] m_ras[$];
`endif

    pc_seq #(
        .ADDR_W(32), .RESET_ADDR(32'h100), .TRAP_ADDR(32'h80), .RAS_DEPTH(RAS_D)
    ) dut (
        .clk(clk), .rest_n(rest_n), .stall(stall), .trap(trap), .zero(zero),
        .great(great), .pc_op(pc_op), .im1(im1), .im2(im2), .j_reg(j_reg),
        .addr(addr), .rt_addr(rt_addr), .epc(epc), .redirect(redirect),
        .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, trap, zero, great;
        logic [3:0]  op;
        logic [15:0] im1;
        logic [25:0] im2;
        logic [31:0] j_reg;
        logic [31:0] exp_addr;
        logic        exp_redirect;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit exp_empty();
`ifdef PC_SEQ_RAS_EN
        return m_ras.size() == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_addr  = RST_A;
        m_rt    = 32'h0;
        m_epc   = 32'h0;
        m_redir = 1'b0;
`ifdef PC_SEQ_RAS_EN
        m_ras.delete();
`endif
    endtask

    // Reference: next PC from the operation rules, using the inputs held for the coming edge.
    task automatic model_update();
        logic [31:0] nxt;
        logic        taken;
        int          off;
        if (trap) begin
            m_epc   = m_addr;
            m_addr  = TRAP_A;
            m_redir = 1'b1;
            return;
        end
        if (stall) begin
            m_redir = 1'b0;
            return;
        end
        off   = 4 * int'($signed(im1));
        taken = (pc_op == OP_BZ    &&  zero) || (pc_op == OP_BNZ   && !zero) ||
                (pc_op == OP_BG    && great) || (pc_op == OP_BNG   && !great) ||
                (pc_op == OP_BGZ   && (zero || great)) ||
                (pc_op == OP_BNGNZ && !zero && !great);
        nxt = m_addr + 32'd4;
        m_redir = 1'b1;
        if (taken)                             nxt = m_addr + 32'(off);
        else if (pc_op == OP_J || pc_op == OP_JAL) nxt = {m_addr[31:28], im2, 2'b00};
        else if (pc_op == OP_JR)               nxt = j_reg;
        else if (pc_op == OP_RET) begin
`ifdef PC_SEQ_RAS_EN
            if (m_ras.size() > 0) nxt = m_ras.pop_back();
            else                  nxt = j_reg;
`else
            nxt = j_reg;
`endif
        end
        else if (pc_op == OP_ERET)             nxt = m_epc;
        else                                   m_redir = 1'b0;
`ifdef PC_SEQ_RAS_EN
        if (pc_op == OP_JAL) begin
            m_ras.push_back(m_addr + 32'd4);
            if (m_ras.size() > RAS_D) void'(m_ras.pop_front());
        end
`endif
        m_rt   = m_addr + 32'd4;
        m_addr = nxt;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".addr"},      addr,      m_addr);
        check({tag, ".rt_addr"},   rt_addr,   m_rt);
        check({tag, ".epc"},       epc,       m_epc);
        check({tag, ".redirect"},  redirect,  m_redir);
        check({tag, ".ras_empty"}, ras_empty, exp_empty());
    endtask

    task automatic tick(input string tag);
        model_update();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic drive(input logic s, input logic t, input logic [3:0] op,
                         input logic [25:0] i2, input logic [31:0] jr);
        stall = s; trap = t; pc_op = op; im2 = i2; j_reg = jr;
    endtask

    initial begin
        vecs[0]  = '{0,0,0,0,OP_JR,   16'h0,   26'h0, 32'h200,       32'h200,       1, 32'h0};
        vecs[1]  = '{0,0,1,0,OP_BZ,   16'hFFFE,26'h0, 32'h0,         32'h1F8,       1, 32'h0};
        vecs[2]  = '{0,0,0,0,OP_BZ,   16'hFFFE,26'h0, 32'h0,         32'h1FC,       0, 32'h0};
        vecs[3]  = '{0,0,0,0,OP_BNZ,  16'h4,   26'h0, 32'h0,         32'h20C,       1, 32'h0};
        vecs[4]  = '{0,0,0,0,OP_BG,   16'h4,   26'h0, 32'h0,         32'h210,       0, 32'h0};
        vecs[5]  = '{0,0,0,0,OP_BNG,  16'h1,   26'h0, 32'h0,         32'h214,       1, 32'h0};
        vecs[6]  = '{0,0,0,0,OP_BGZ,  16'h1,   26'h0, 32'h0,         32'h218,       0, 32'h0};
        vecs[7]  = '{0,0,0,0,OP_BNGNZ,16'h2,   26'h0, 32'h0,         32'h220,       1, 32'h0};
        vecs[8]  = '{0,0,0,0,OP_JR,   16'h0,   26'h0, 32'h300,       32'h300,       1, 32'h0};
        vecs[9]  = '{1,0,0,0,OP_JR,   16'h0,   26'h0, 32'h555,       32'h300,       0, 32'h0};
        vecs[10] = '{1,0,1,0,OP_BZ,   16'h8,   26'h0, 32'h0,         32'h300,       0, 32'h0};
        vecs[11] = '{1,1,0,0,OP_JR,   16'h0,   26'h0, 32'h777,       32'h80,        1, 32'h300};
        vecs[12] = '{0,0,0,0,OP_ERET, 16'h0,   26'h0, 32'h0,         32'h300,       1, 32'h300};
        vecs[13] = '{0,0,0,0,OP_JR,   16'h0,   26'h0, 32'hF000_0010, 32'hF000_0010, 1, 32'h300};
        vecs[14] = '{0,0,0,0,OP_J,    16'h0,   26'h3, 32'h0,         32'hF000_000C, 1, 32'h300};
        vecs[15] = '{0,0,0,0,OP_JR,   16'h0,   26'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h300};
        vecs[16] = '{0,0,0,0,OP_SEQ,  16'h0,   26'h0, 32'h0,         32'h0000_0000, 0, 32'h300};
        vecs[17] = '{0,0,0,0,4'hF,    16'h0,   26'h0, 32'h0,         32'h0000_0004, 0, 32'h300};

        rest_n = 1'b0;
        stall = 0; trap = 0; zero = 0; great = 0;
        pc_op = OP_SEQ; im1 = '0; im2 = '0; j_reg = '0;
        model_reset();

        // Reset held across an edge, then released between edges.
        #12;
        check("rst.addr",      addr,      RST_A);
        check("rst.rt_addr",   rt_addr,   32'h0);
        check("rst.epc",       epc,       32'h0);
        check("rst.redirect",  redirect,  1'b0);
        check("rst.ras_empty", ras_empty, 1'b1);
        rest_n = 1'b1;
        #1;
        check("rel.addr", addr, RST_A);
        for (int i = 1; i <= 3; i++) begin
            tick("free");
            check("free.addr_const", addr, RST_A + 32'(4 * i));
            check("free.redirect_const", redirect, 1'b0);
        end

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            stall = vecs[i].stall; trap = vecs[i].trap;
            zero  = vecs[i].zero;  great = vecs[i].great;
            pc_op = vecs[i].op;    im1 = vecs[i].im1;
            im2   = vecs[i].im2;   j_reg = vecs[i].j_reg;
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.addr_tbl", i),     addr,     vecs[i].exp_addr);
            check($sformatf("vec%0d.redirect_tbl", i), redirect, vecs[i].exp_redirect);
            check($sformatf("vec%0d.epc_tbl", i),      epc,      vecs[i].exp_epc);
        end

        // Return-stack sequence: depth 2, three calls then three returns.
        zero = 0; great = 0; im1 = '0;
        drive(0, 0, OP_JR,  26'h0,  32'h10);  tick("ras.jr");
        drive(0, 0, OP_JAL, 26'h8,  32'h0);   tick("ras.jal1");
        check("ras.jal1.rt", rt_addr, 32'h14);
        drive(0, 0, OP_JAL, 26'hC,  32'h0);   tick("ras.jal2");
        drive(0, 0, OP_JAL, 26'h10, 32'h0);   tick("ras.jal3");
        check("ras.jal3.addr", addr, 32'h40);
`ifdef PC_SEQ_RAS_EN
        check("ras.full.empty", ras_empty, 1'b0);
`endif
        drive(0, 0, OP_RET, 26'h0, 32'h999);  tick("ras.ret1");
`ifdef PC_SEQ_RAS_EN
        check("ras.ret1.addr", addr, 32'h34);
`else
        check("ras.ret1.addr", addr, 32'h999);
`endif
        tick("ras.ret2");
`ifdef PC_SEQ_RAS_EN
        check("ras.ret2.addr", addr, 32'h24);
`else
        check("ras.ret2.addr", addr, 32'h999);
`endif
        tick("ras.ret3");
        check("ras.ret3.addr",  addr,      32'h999);
        check("ras.ret3.empty", ras_empty, 1'b1);

        // Asynchronous reset between edges while a RET is presented.
        drive(0, 0, OP_JAL, 26'h40, 32'h0);   tick("arst.jal");
        drive(0, 0, OP_RET, 26'h0, 32'h444);
        #3;
        rest_n = 1'b0;
        #1;
        model_reset();
        check("arst.addr",      addr,      RST_A);
        check("arst.ras_empty", ras_empty, 1'b1);
        check("arst.redirect",  redirect,  1'b0);
        check("arst.rt_addr",   rt_addr,   32'h0);
        check("arst.epc",       epc,       32'h0);
        @(posedge clk);
        #1;
        rest_n = 1'b1;
        drive(0, 0, OP_SEQ, 26'h0, 32'h0);
        tick("arst.first");
        check("arst.first.addr", addr, RST_A + 32'h4);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            trap  = ($urandom_range(0, 15) == 0);
            zero  = 1'($urandom);
            great = 1'($urandom);
            pc_op = 4'($urandom);
            im1   = 16'($urandom);
            im2   = 26'($urandom);
            j_reg = $urandom;
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
